// File: rtl/alu_pkg.sv
// Shared ALUCtl encodings used by the ALU control decoder and the execute stage.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_BAD = 4'b1111;

    function automatic logic is_legal_ctl(input logic [3:0] ctl);
        return (ctl == ALU_AND) || (ctl == ALU_OR)  || (ctl == ALU_ADD) ||
               (ctl == ALU_SUB) || (ctl == ALU_SLT) || (ctl == ALU_NOR);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: evaluates one ALUCtl operation with zero/overflow/illegal flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_ctl,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_ovf,
    output logic             o_illegal
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_ovf_add;
    logic             w_ovf_sub;

    assign w_sum     = i_a + i_b;
    assign w_diff    = i_a - i_b;
    assign w_ovf_add = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB]  != i_a[MSB]);
    assign w_ovf_sub = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        o_result  = '0;
        o_ovf     = 1'b0;
        o_illegal = !is_legal_ctl(i_ctl);
        unique case (i_ctl)
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_ADD: begin
                o_result = w_sum;
                o_ovf    = w_ovf_add;
            end
            ALU_SUB: begin
                o_result = w_diff;
                o_ovf    = w_ovf_sub;
            end
            // Signed less-than: the true sign of a-b is the raw sign corrected by overflow.
            ALU_SLT: o_result[0] = w_diff[MSB] ^ w_ovf_sub;
            ALU_NOR: o_result = ~(i_a | i_b);
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_exec_pipe.sv
// Execute stage: valid/ready handshake around alu_core with two registered stages and full backpressure.
module alu_exec_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_ctl,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_illegal
);

    logic             r_s1_valid;
    logic [3:0]       r_s1_ctl;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_result;
    logic             r_s2_zero;
    logic             r_s2_ovf;
    logic             r_s2_illegal;

    logic             w_s1_advance;
    logic [WIDTH-1:0] w_result;
    logic             w_zero;
    logic             w_ovf;
    logic             w_illegal;

    // S2 is free when empty or draining this cycle; S1 may refill whenever it moves on or is empty.
    assign w_s1_advance = !r_s2_valid || out_ready;
    assign in_ready     = !r_s1_valid || w_s1_advance;

    // NOTE: operand registers carry no reset; r_s1_valid alone qualifies them, so stale data is harmless.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
        end else if (in_ready) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_ctl <= in_ctl;
                r_s1_a   <= in_a;
                r_s1_b   <= in_b;
            end
        end
    end

    alu_core #(
        .WIDTH(WIDTH)
    ) u_alu_core (
        .i_ctl    (r_s1_ctl),
        .i_a      (r_s1_a),
        .i_b      (r_s1_b),
        .o_result (w_result),
        .o_zero   (w_zero),
        .o_ovf    (w_ovf),
        .o_illegal(w_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid   <= 1'b0;
            r_s2_result  <= '0;
            r_s2_zero    <= 1'b0;
            r_s2_ovf     <= 1'b0;
            r_s2_illegal <= 1'b0;
        end else if (w_s1_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_result  <= w_result;
                r_s2_zero    <= w_zero;
                r_s2_ovf     <= w_ovf;
                r_s2_illegal <= w_illegal;
            end
        end
    end

    assign out_valid   = r_s2_valid;
    assign out_result  = r_s2_result;
    assign out_zero    = r_s2_zero;
    assign out_ovf     = r_s2_ovf;
    assign out_illegal = r_s2_illegal;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed self-checking bench for alu_exec_pipe: op table, backpressure and reset-mid-stall sequences.
module tb_alu_exec_pipe;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_result;
        logic        exp_zero;
        logic        exp_ovf;
        logic        exp_illegal;
        string       name;
    } vec_t;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_ctl;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_ovf;
    logic             out_illegal;

    int n_checks = 0;
    int n_errors = 0;

    vec_t vecs[13];

    alu_exec_pipe #(
        .WIDTH(WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctl     (in_ctl),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_ovf    (out_ovf),
        .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_ctl   = ctl;
        in_a     = a;
        in_b     = b;
    endtask

    // One request in an empty pipe: accepted at the next edge, visible two cycles after it was driven.
    task automatic run_one(input vec_t v);
        @(negedge clk);
        drive(v.ctl, v.a, v.b);
        #1;
        check({v.name, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check({v.name, " early out_valid"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check({v.name, " out_valid"}, 32'(out_valid), 32'd1);
        check({v.name, " result"}, out_result, v.exp_result);
        check({v.name, " zero"}, 32'(out_zero), 32'(v.exp_zero));
        check({v.name, " ovf"}, 32'(out_ovf), 32'(v.exp_ovf));
        check({v.name, " illegal"}, 32'(out_illegal), 32'(v.exp_illegal));
    endtask

    initial begin
        logic [31:0] got[$];
        int          idx;
        logic        acc;

        vecs[0]  = '{ALU_ADD, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0, "add"};
        vecs[1]  = '{ALU_SUB, 32'd7,          32'd7,          32'd0,          1'b1, 1'b0, 1'b0, "sub_zero"};
        vecs[2]  = '{ALU_AND, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  1'b0, 1'b0, 1'b0, "and"};
        vecs[3]  = '{ALU_OR,  32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1'b0, 1'b0, 1'b0, "or"};
        vecs[4]  = '{ALU_NOR, 32'h0,          32'h0,          32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0, "nor"};
        vecs[5]  = '{ALU_ADD, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b1, 1'b0, "add_ovf"};
        vecs[6]  = '{ALU_SUB, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b1, 1'b0, "sub_ovf"};
        vecs[7]  = '{ALU_SLT, 32'h8000_0000,  32'd1,          32'd1,          1'b0, 1'b0, 1'b0, "slt_neg"};
        vecs[8]  = '{ALU_SLT, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0, 1'b0, "slt_pos"};
        vecs[9]  = '{ALU_SLT, 32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          1'b1, 1'b0, 1'b0, "slt_ovf"};
        vecs[10] = '{ALU_BAD, 32'h1234_5678,  32'h1111_1111,  32'd0,          1'b1, 1'b0, 1'b1, "ill_1111"};
        vecs[11] = '{4'b0011, 32'h7FFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 1'b1, "ill_0011"};
        vecs[12] = '{ALU_ADD, 32'd2,          32'd3,          32'd5,          1'b0, 1'b0, 1'b0, "add_after_ill"};

        // Reset held two cycles with a request presented.
        reset     = 1'b1;
        out_ready = 1'b1;
        drive(ALU_ADD, 32'd1, 32'd1);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check("rst out_valid", 32'(out_valid), 32'd0);
            check("rst out_result", out_result, 32'd0);
            check("rst flags", {29'd0, out_zero, out_ovf, out_illegal}, 32'd0);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post-rst in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("post-rst no output", 32'(out_valid), 32'd0);

        for (int i = 0; i < 13; i++) run_one(vecs[i]);

        // Backpressure: four ADDs (i+1) with the output stalled.
        @(negedge clk);
        out_ready = 1'b0;
        drive(ALU_ADD, 32'd0, 32'd1);
        #1;
        check("bp accept0 in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive(ALU_ADD, 32'd1, 32'd1);
        #1;
        check("bp accept1 in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive(ALU_ADD, 32'd2, 32'd1);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp full in_ready", 32'(in_ready), 32'd0);
            check("bp hold out_valid", 32'(out_valid), 32'd1);
            check("bp hold result", out_result, 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        idx = 2;
        for (int cyc = 0; cyc < 20 && got.size() < 4; cyc++) begin
            #1;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) got.push_back(out_result);
            @(posedge clk);
            @(negedge clk);
            if (acc) begin
                if (idx < 3) begin
                    idx++;
                    in_a = 32'(idx);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("bp delivered count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("bp order", (i < got.size()) ? got[i] : 32'hDEAD_DEAD, 32'(i + 1));
        in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("bp no duplicate", 32'(out_valid), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end

        // Reset while two requests sit in a stalled pipe.
        out_ready = 1'b0;
        drive(ALU_ADD, 32'd100, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive(ALU_ADD, 32'd200, 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("stall full out_valid", 32'(out_valid), 32'd1);
        check("stall full result", out_result, 32'd100);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst result", out_result, 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check("midrst old discarded", 32'(out_valid), 32'd0);
        end
        run_one('{ALU_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0, "post_midrst"});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
